uram_nrw_arb: RTL and testbench

//  Multi-channel front end for one UltraRAM array: NUM_CH request channels share two physical RW ports.
//  A round-robin arbiter grants up to two requests per cycle, one to port A and one to port B.

---
 rtl/uram_arb_pkg.sv | 30 +++
 rtl/uram_nrw_arb_rr.sv | 55 +++++
 rtl/uram_nrw_arb.sv | 176 +++++++++++++++++
 tb/tb_uram_nrw_arb.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uram_arb_pkg.sv
// Shared types and sizing for the multi-channel UltraRAM arbiter.
// The URAM_ARB_STATS_EN macro enables the stall counter in uram_nrw_arb.
package uram_arb_pkg;

    localparam int NUM_CH_D = 4;
    localparam int DWIDTH_D = 8;
    localparam int LWIDTH_D = 64;
    localparam int AWIDTH_D = 16;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sel_bits(input int lw, input int dw);
        return $clog2(lw / dw);
    endfunction

    localparam int CH_W     = ch_w(NUM_CH_D);
    localparam int SEL_BITS = sel_bits(LWIDTH_D, DWIDTH_D);
    localparam int LINE_W   = AWIDTH_D - SEL_BITS;

    typedef struct packed {
        logic                wr;
        logic [LINE_W-1:0]   line;
        logic [SEL_BITS-1:0] sel;
        logic [CH_W-1:0]     ch;
        logic [LWIDTH_D-1:0] wdata;
    } req_t;

endpackage

// File: rtl/uram_nrw_arb_rr.sv
// Combinational two-grant round-robin picker: port A takes the first
// requester from ptr, port B the next one after A unless they conflict.
module rr_arb_2grant
    import uram_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic [N-1:0]   valid,
    input  logic [CW-1:0]  ptr,
    input  logic [N*N-1:0] conflict,
    output logic [N-1:0]   gnt_a,
    output logic [N-1:0]   gnt_b,
    output logic [CW-1:0]  idx_a,
    output logic [CW-1:0]  idx_b,
    output logic [CW-1:0]  last
);

    logic          found_a;
    logic          found_b;
    logic [CW-1:0] idx;

    always_comb begin
        gnt_a   = '0;
        gnt_b   = '0;
        found_a = 1'b0;
        found_b = 1'b0;
        idx_a   = '0;
        idx_b   = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = CW'((int'(ptr) + i) % N);
            if (!found_a && valid[idx]) begin
                found_a = 1'b1;
                idx_a   = idx;
            end
        end
        for (int j = 1; j < N; j++) begin
            idx = CW'((int'(idx_a) + j) % N);
            if (found_a && !found_b && valid[idx]) begin
                found_b = 1'b1;
                idx_b   = idx;
            end
        end
        // A blocked B candidate is not replaced by a later channel
        if (found_b && conflict[int'(idx_a) * N + int'(idx_b)])
            found_b = 1'b0;
        if (found_a)
            gnt_a[idx_a] = 1'b1;
        if (found_b)
            gnt_b[idx_b] = 1'b1;
        last = found_b ? idx_b : idx_a;
    end

endmodule

// File: rtl/uram_nrw_arb.sv
// NUM_CH request channels sharing a two-port UltraRAM through a 3-stage pipe.
// Define URAM_ARB_STATS_EN to build the saturating stall counter.
module uram_nrw_arb
    import uram_arb_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_D,
    parameter int DWIDTH = DWIDTH_D,
    parameter int LWIDTH = LWIDTH_D,
    parameter int AWIDTH = AWIDTH_D
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_wr,
    input  logic [NUM_CH*AWIDTH-1:0] req_addr,
    input  logic [NUM_CH*LWIDTH-1:0] req_wdata,
    output logic [NUM_CH-1:0]        resp_valid,
    output logic [NUM_CH*DWIDTH-1:0] resp_data,
    output logic [31:0]              stall_cnt
);

    localparam int LINES = 1 << LINE_W;

    logic [NUM_CH*NUM_CH-1:0] conf;
    logic [NUM_CH-1:0]        gnt_a;
    logic [NUM_CH-1:0]        gnt_b;
    logic [CH_W-1:0]          idx_a;
    logic [CH_W-1:0]          idx_b;
    logic [CH_W-1:0]          last;
    logic [CH_W-1:0]          rr_ptr;
    logic [CH_W-1:0]          next_ptr;
    req_t                     req_a;
    req_t                     req_b;

    function automatic req_t mk_req(input logic [CH_W-1:0] c);
        req_t              r;
        logic [AWIDTH-1:0] a;
        a       = req_addr[c*AWIDTH +: AWIDTH];
        r.wr    = req_wr[c];
        r.line  = a[AWIDTH-1:SEL_BITS];
        r.sel   = a[SEL_BITS-1:0];
        r.ch    = c;
        r.wdata = req_wdata[c*LWIDTH +: LWIDTH];
        return r;
    endfunction

    always_comb begin
        conf = '0;
        for (int i = 0; i < NUM_CH; i++)
            for (int j = 0; j < NUM_CH; j++)
                if ((req_wr[i] || req_wr[j]) &&
                    req_addr[i*AWIDTH+SEL_BITS +: LINE_W] ==
                    req_addr[j*AWIDTH+SEL_BITS +: LINE_W])
                    conf[i*NUM_CH+j] = 1'b1;
    end

    rr_arb_2grant #(.N(NUM_CH), .CW(CH_W)) u_arb (
        .valid    (req_valid),
        .ptr      (rr_ptr),
        .conflict (conf),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .idx_a    (idx_a),
        .idx_b    (idx_b),
        .last     (last)
    );

    assign req_ready = reset ? '0 : (gnt_a | gnt_b);
    assign next_ptr  = CH_W'((int'(last) + 1) % NUM_CH);
    assign req_a     = mk_req(idx_a);
    assign req_b     = mk_req(idx_b);

    // Stage 1: accepted requests
    req_t       s1 [2];
    logic [1:0] s1_v;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            s1_v   <= '0;
            s1[0]  <= '0;
            s1[1]  <= '0;
        end else begin
            if (|req_ready)
                rr_ptr <= next_ptr;
            s1_v  <= {|gnt_b, |gnt_a};
            s1[0] <= req_a;
            s1[1] <= req_b;
        end
    end

    // Stage 2: URAM access, one process per physical port
    (* ram_style = "ultra" *) logic [LWIDTH-1:0] mem [LINES];
    logic [LWIDTH-1:0] line_a;
    logic [LWIDTH-1:0] line_b;

    always @(posedge clock) begin
        if (s1_v[0]) begin
            if (s1[0].wr)
                mem[s1[0].line] <= s1[0].wdata;
            else
                line_a <= mem[s1[0].line];
        end
    end

    always @(posedge clock) begin
        if (s1_v[1]) begin
            if (s1[1].wr)
                mem[s1[1].line] <= s1[1].wdata;
            else
                line_b <= mem[s1[1].line];
        end
    end

    logic [1:0]          s2_rd;
    logic [SEL_BITS-1:0] s2_sel [2];
    logic [CH_W-1:0]     s2_ch  [2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_rd     <= '0;
            s2_sel[0] <= '0;
            s2_sel[1] <= '0;
            s2_ch[0]  <= '0;
            s2_ch[1]  <= '0;
        end else begin
            s2_rd     <= s1_v & ~{s1[1].wr, s1[0].wr};
            s2_sel[0] <= s1[0].sel;
            s2_sel[1] <= s1[1].sel;
            s2_ch[0]  <= s1[0].ch;
            s2_ch[1]  <= s1[1].ch;
        end
    end

    // Stage 3: narrow and route to the owning channel
    logic [NUM_CH-1:0]        rv_n;
    logic [NUM_CH*DWIDTH-1:0] rd_n;

    always_comb begin
        rv_n = '0;
        rd_n = resp_data;
        if (s2_rd[0]) begin
            rv_n[s2_ch[0]] = 1'b1;
            rd_n[s2_ch[0]*DWIDTH +: DWIDTH] =
                line_a[s2_sel[0]*DWIDTH +: DWIDTH];
        end
        if (s2_rd[1]) begin
            rv_n[s2_ch[1]] = 1'b1;
            rd_n[s2_ch[1]*DWIDTH +: DWIDTH] =
                line_b[s2_sel[1]*DWIDTH +: DWIDTH];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= rv_n;
            resp_data  <= rd_n;
        end
    end

`ifdef URAM_ARB_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (|(req_valid & ~req_ready) && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_uram_nrw_arb.sv
// Directed bench for uram_nrw_arb: latency, round-robin order, conflicts,
// same-line reads, reset flush and the optional stall counter.
module tb_uram_nrw_arb;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [3:0]   req_wr;
    logic [63:0]  req_addr;
    logic [255:0] req_wdata;
    logic [3:0]   resp_valid;
    logic [31:0]  resp_data;
    logic [31:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    uram_nrw_arb dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .stall_cnt  (stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int ch, input logic wr,
                           input logic [15:0] addr, input logic [63:0] data);
        req_valid[ch]           = 1'b1;
        req_wr[ch]              = wr;
        req_addr[ch*16 +: 16]   = addr;
        req_wdata[ch*64 +: 64]  = data;
    endtask

    logic [3:0] exp_rdy;
    logic [3:0] exp_rv;
    logic [7:0] b;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        set_req(0, 1'b0, 16'd0, 64'd0);
        cyc();
        cyc();
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_resp_data", 64'(resp_data), 64'h0);
        chk("rst_stall", 64'(stall_cnt), 64'h0);
        req_valid = '0;
        reset = 1'b0;

        // 1: write line 0, read addr 5
        set_req(0, 1'b1, 16'd0, 64'h0706050403020100);
        #1 chk("t1_wr_ready", 64'(req_ready), 64'h1);
        cyc();
        req_valid = '0;
        set_req(1, 1'b0, 16'd5, 64'd0);
        #1 chk("t1_rd_ready", 64'(req_ready), 64'h2);
        cyc();
        req_valid = '0;
        chk("t1_lat1", 64'(resp_valid), 64'h0);
        cyc();
        chk("t1_lat2", 64'(resp_valid), 64'h0);
        cyc();
        chk("t1_resp_valid", 64'(resp_valid), 64'h2);
        chk("t1_resp_data", 64'(resp_data[15:8]), 64'h05);
        cyc();
        chk("t1_pulse", 64'(resp_valid), 64'h0);

        // 2: four continuous readers of line 0
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int c = 0; c < 4; c++)
            set_req(c, 1'b0, 16'(c), 64'd0);
        for (int k = 0; k < 9; k++) begin
            if (k == 6)
                req_valid = '0;
            #1;
            exp_rdy = (k >= 6) ? 4'h0 : ((k % 2 == 0) ? 4'h3 : 4'hC);
            chk($sformatf("t2_ready_%0d", k), 64'(req_ready), 64'(exp_rdy));
            if (k >= 3) begin
                exp_rv = ((k - 3) % 2 == 0) ? 4'h3 : 4'hC;
                chk($sformatf("t2_rv_%0d", k), 64'(resp_valid), 64'(exp_rv));
                for (int c = 0; c < 4; c++)
                    if (exp_rv[c]) begin
                        b = resp_data[c*8 +: 8];
                        chk($sformatf("t2_rd_%0d_%0d", k, c), 64'(b), 64'(c));
                    end
            end
            cyc();
        end
        chk("t2_drain", 64'(resp_valid), 64'h0);

        // 3: write/read same line, B blocked then served next cycle
        set_req(3, 1'b1, 16'd8, 64'h0F0E0D0C0B0A0908);
        #1 chk("t3_pre_ready", 64'(req_ready), 64'h8);
        cyc();
        req_valid = '0;
        set_req(0, 1'b1, 16'd16, 64'hA7A6A5A4A3A2A1A0);
        set_req(1, 1'b0, 16'd19, 64'd0);
        #1 chk("t3_conf_ready", 64'(req_ready), 64'h1);
        cyc();
        req_valid[0] = 1'b0;
        #1 chk("t3_retry_ready", 64'(req_ready), 64'h2);
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        chk("t3_resp_valid", 64'(resp_valid), 64'h2);
        chk("t3_resp_data", 64'(resp_data[15:8]), 64'hA3);
        cyc();

        // 4: read/read to the same line in one cycle
        set_req(2, 1'b0, 16'd8, 64'd0);
        set_req(3, 1'b0, 16'd9, 64'd0);
        #1 chk("t4_ready", 64'(req_ready), 64'hC);
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        chk("t4_resp_valid", 64'(resp_valid), 64'hC);
        chk("t4_resp_ch2", 64'(resp_data[23:16]), 64'h08);
        chk("t4_resp_ch3", 64'(resp_data[31:24]), 64'h09);
        cyc();

        // 5: reset drops in-flight reads
        set_req(0, 1'b0, 16'd1, 64'd0);
        set_req(1, 1'b0, 16'd2, 64'd0);
        #1 chk("t5_ready", 64'(req_ready), 64'h3);
        cyc();
        req_valid = '0;
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5_quiet_%0d", k), 64'(resp_valid), 64'h0);
            cyc();
        end

        // 6: four requesters for 10 cycles; ch0 first after reset
        for (int c = 0; c < 4; c++)
            set_req(c, 1'b0, 16'(c), 64'd0);
        #1 chk("t5_first_grant", 64'(req_ready), 64'h3);
        for (int k = 0; k < 10; k++)
            cyc();
`ifdef URAM_ARB_STATS_EN
        chk("t6_stall_cnt", 64'(stall_cnt), 64'd10);
`else
        chk("t6_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        req_valid = '0;
        cyc();
        cyc();
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
